instruction_fetch: RTL and testbench

- Front-end stage of the 8051-based pipeline.
- Generates the program counter and issues word reads to the synchronous program ROM.
- Buffers returned instructions in a 2-entry prefetch queue and presents one instruction per cycle in the Instruction Register (o_ir), which feeds decode and the hazard unit.
- Consumes the hazard unit's branch decision (i_pc_load) to redirect fetch and squash wrong-path instructions.

---
 rtl/instruction_fetch_pkg.sv | 28 ++
 rtl/instruction_fetch_queue.sv | 62 ++++++
 rtl/instruction_fetch.sv | 125 ++++++++++++
 tb/tb_instruction_fetch.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the 8051 pipeline front end: IR layout, bubble word and opcode names.
package instruction_fetch_pkg;

    localparam int unsigned IR_W        = 16;
    localparam int unsigned OPCODE_MSB  = 15;
    localparam int unsigned OPCODE_LSB  = 8;
    localparam int unsigned OPERAND_MSB = 7;
    localparam int unsigned OPERAND_LSB = 0;

    localparam logic [IR_W-1:0] NOP_INSTR_DEFAULT = 16'h0000;

    typedef enum logic [7:0] {
        OP_NOP  = 8'h00,
        OP_AJMP = 8'h01,
        OP_LJMP = 8'h02,
        OP_JZ   = 8'h60,
        OP_SJMP = 8'h80
    } opcode_e;

    function automatic logic [7:0] ir_opcode(input logic [IR_W-1:0] ir);
        return ir[OPCODE_MSB:OPCODE_LSB];
    endfunction

    function automatic logic [7:0] ir_operand(input logic [IR_W-1:0] ir);
        return ir[OPERAND_MSB:OPERAND_LSB];
    endfunction

endpackage

// File: rtl/instruction_fetch_queue.sv
// Two-entry prefetch FIFO of {pc, instr}; clear wins over push, and push+pop while full is allowed.
module fetch_queue
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_pc,
    input  logic [IR_W-1:0]   push_instr,
    input  logic              pop,
    output logic [ADDR_W-1:0] head_pc,
    output logic [IR_W-1:0]   head_instr,
    output logic [1:0]        occupancy,
    output logic              full,
    output logic              empty
);

    logic [ADDR_W-1:0] pc_mem    [2];
    logic [IR_W-1:0]   instr_mem [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;
    logic              do_push;
    logic              do_pop;

    always_comb begin
        empty      = (count_q == 2'd0);
        full       = (count_q == 2'd2);
        occupancy  = count_q;
        head_pc    = pc_mem[rd_ptr_q];
        head_instr = instr_mem[rd_ptr_q];
        do_pop     = pop && !empty;
        do_push    = push && (!full || do_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) wr_ptr_q <= !wr_ptr_q;
            if (do_pop)  rd_ptr_q <= !rd_ptr_q;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            pc_mem[wr_ptr_q]    <= push_pc;
            instr_mem[wr_ptr_q] <= push_instr;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC generation, ROM request issue, prefetch buffering and the Instruction Register.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [IR_W-1:0]   NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_stall,
    input  logic              i_pc_load,
    input  logic [ADDR_W-1:0] i_pc_target,
    output logic              o_imem_en,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic [IR_W-1:0]   i_imem_rdata,
    output logic [IR_W-1:0]   o_ir,
    output logic              o_ir_valid,
    output logic [ADDR_W-1:0] o_ir_pc
);

    logic              run_q;
    logic [ADDR_W-1:0] fetch_pc_q;
    logic              epoch_q;
    logic              inflight_q;
    logic              inflight_epoch_q;
    logic [ADDR_W-1:0] inflight_pc_q;
    logic [IR_W-1:0]   ir_q;
    logic              ir_valid_q;
    logic [ADDR_W-1:0] ir_pc_q;

    logic [1:0]        occupancy;
    logic              q_full;
    logic              q_empty;
    logic [ADDR_W-1:0] head_pc;
    logic [IR_W-1:0]   head_instr;

    logic              resp_live;
    logic [1:0]        pending;
    logic              accept;
    logic              redirect;
    logic              bypass;
    logic              q_push;
    logic              q_pop;

    fetch_queue #(
        .ADDR_W (ADDR_W)
    ) u_queue (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .clear      (redirect),
        .push       (q_push),
        .push_pc    (inflight_pc_q),
        .push_instr (i_imem_rdata),
        .pop        (q_pop),
        .head_pc    (head_pc),
        .head_instr (head_instr),
        .occupancy  (occupancy),
        .full       (q_full),
        .empty      (q_empty)
    );

    // A response is live only if it was issued in the current epoch; a redirect
    // toggles the epoch, so the read issued in the redirect cycle is dropped on return.
    always_comb begin
        resp_live = inflight_q && (inflight_epoch_q == epoch_q);
        pending   = occupancy + {1'b0, resp_live};
        accept    = !i_stall || !ir_valid_q;
        redirect  = i_pc_load && ir_valid_q && !i_stall;
        q_pop     = accept && !redirect && !q_empty;
        bypass    = accept && !redirect && q_empty && resp_live;
        q_push    = resp_live && !redirect && !bypass && (!q_full || q_pop);
        o_imem_en = run_q && (pending < 2'd2);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            run_q            <= 1'b0;
            fetch_pc_q       <= RESET_PC;
            epoch_q          <= 1'b0;
            inflight_q       <= 1'b0;
            inflight_epoch_q <= 1'b0;
            inflight_pc_q    <= RESET_PC;
            ir_q             <= NOP_INSTR;
            ir_valid_q       <= 1'b0;
            ir_pc_q          <= RESET_PC;
        end else begin
            run_q            <= 1'b1;
            inflight_q       <= o_imem_en;
            inflight_epoch_q <= epoch_q;
            inflight_pc_q    <= fetch_pc_q;

            if (redirect) begin
                fetch_pc_q <= i_pc_target;
                epoch_q    <= !epoch_q;
            end else if (o_imem_en) begin
                fetch_pc_q <= fetch_pc_q + ADDR_W'(1);
            end

            if (redirect) begin
                ir_q       <= NOP_INSTR;
                ir_valid_q <= 1'b0;
            end else if (accept) begin
                if (!q_empty) begin
                    ir_q       <= head_instr;
                    ir_pc_q    <= head_pc;
                    ir_valid_q <= 1'b1;
                end else if (bypass) begin
                    ir_q       <= i_imem_rdata;
                    ir_pc_q    <= inflight_pc_q;
                    ir_valid_q <= 1'b1;
                end else begin
                    ir_q       <= NOP_INSTR;
                    ir_valid_q <= 1'b0;
                end
            end
        end
    end

    assign o_imem_addr = fetch_pc_q;
    assign o_ir        = ir_q;
    assign o_ir_valid  = ir_valid_q;
    assign o_ir_pc     = ir_pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: expected instruction stream queued by stimulus, checked by a monitor.
module tb_instruction_fetch;

    localparam int unsigned ADDR_W   = 8;
    localparam logic [7:0]  RESET_PC = 8'h00;
    localparam logic [15:0] NOP      = 16'h0000;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_stall;
    logic        i_pc_load;
    logic [7:0]  i_pc_target;
    logic        o_imem_en;
    logic [7:0]  o_imem_addr;
    logic [15:0] i_imem_rdata;
    logic [15:0] o_ir;
    logic        o_ir_valid;
    logic [7:0]  o_ir_pc;

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  model_pc;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    instruction_fetch #(
        .ADDR_W    (ADDR_W),
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_stall      (i_stall),
        .i_pc_load    (i_pc_load),
        .i_pc_target  (i_pc_target),
        .o_imem_en    (o_imem_en),
        .o_imem_addr  (o_imem_addr),
        .i_imem_rdata (i_imem_rdata),
        .o_ir         (o_ir),
        .o_ir_valid   (o_ir_valid),
        .o_ir_pc      (o_ir_pc)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [15:0] rom_word(input logic [7:0] a);
        return 16'h1000 + {8'h00, a};
    endfunction

    // Synchronous ROM: data valid for one cycle after a request, junk otherwise.
    always @(posedge i_clk) begin
        if (o_imem_en === 1'b1) i_imem_rdata <= rom_word(o_imem_addr);
        else                    i_imem_rdata <= 16'($urandom);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic refill();
        while (exp_q.size() < 4) begin
            exp_q.push_back('{model_pc, rom_word(model_pc)});
            model_pc++;
        end
    endtask

    task automatic restart_stream(input logic [7:0] pc);
        exp_q.delete();
        model_pc = pc;
        refill();
    endtask

    // Drive one cycle's inputs; the architectural stream restarts on reset or a taken branch.
    task automatic apply(input logic rst_n, input logic stall, input logic load, input logic [7:0] tgt);
        i_rst_n     = rst_n;
        i_stall     = stall;
        i_pc_load   = load;
        i_pc_target = tgt;
        if (!rst_n)
            restart_stream(RESET_PC);
        else if (load && !stall && o_ir_valid === 1'b1)
            restart_stream(tgt);
        refill();
    endtask

    task automatic wait_ir(input logic [7:0] pc);
        int unsigned n = 0;
        while (!(o_ir_valid === 1'b1 && o_ir_pc == pc) && n < 40) begin
            @(negedge i_clk);
            apply(1'b1, 1'b0, 1'b0, 8'h00);
            n++;
        end
        chk("wait_ir_pc", 32'(o_ir_pc), 32'(pc));
    endtask

    // Monitor: pops the expected stream on every new IR instruction and checks timing rules.
    initial begin
        logic        prev_valid;
        logic [15:0] prev_ir;
        logic [7:0]  prev_pc;
        logic        frozen;
        logic        redir;
        int unsigned since_rst;
        int unsigned redir_age;
        exp_t        e;
        prev_valid = 1'b0;
        prev_ir    = '0;
        prev_pc    = '0;
        since_rst  = 0;
        redir_age  = 0;
        forever begin
            @(posedge i_clk);
            #1;
            if (i_rst_n !== 1'b1) begin
                chk("reset_ir_valid", 32'(o_ir_valid), 32'd0);
                chk("reset_imem_en", 32'(o_imem_en), 32'd0);
                chk("reset_ir", 32'(o_ir), 32'(NOP));
                chk("reset_ir_pc", 32'(o_ir_pc), 32'(RESET_PC));
                chk("reset_imem_addr", 32'(o_imem_addr), 32'(RESET_PC));
                since_rst  = 0;
                redir_age  = 0;
                prev_valid = 1'b0;
            end else begin
                since_rst++;
                frozen = prev_valid && i_stall;
                redir  = prev_valid && !i_stall && i_pc_load;
                if (since_rst == 1) begin
                    chk("startup_imem_en", 32'(o_imem_en), 32'd1);
                    chk("startup_imem_addr", 32'(o_imem_addr), 32'(RESET_PC));
                end
                if (since_rst <= 2)
                    chk("startup_bubble", 32'(o_ir_valid), 32'd0);
                else if (since_rst == 3)
                    chk("startup_first_valid", 32'(o_ir_valid), 32'd1);

                if (frozen) begin
                    chk("stall_hold_valid", 32'(o_ir_valid), 32'd1);
                    chk("stall_hold_ir", 32'(o_ir), 32'(prev_ir));
                    chk("stall_hold_pc", 32'(o_ir_pc), 32'(prev_pc));
                    chk("stall_issue_stop", 32'(o_imem_en), 32'd0);
                end else if (redir) begin
                    chk("redirect_bubble1", 32'(o_ir_valid), 32'd0);
                    redir_age = 1;
                end else begin
                    if (redir_age == 1) begin
                        chk("redirect_bubble2", 32'(o_ir_valid), 32'd0);
                        redir_age = 2;
                    end else if (redir_age == 2) begin
                        chk("redirect_target_valid", 32'(o_ir_valid), 32'd1);
                        redir_age = 0;
                    end else if (prev_valid) begin
                        chk("stream_no_gap", 32'(o_ir_valid), 32'd1);
                    end
                    if (o_ir_valid === 1'b1) begin
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL scoreboard_underflow: got pc %0h expected no instruction", o_ir_pc);
                        end else begin
                            e = exp_q.pop_front();
                            chk("ir_pc", 32'(o_ir_pc), 32'(e.pc));
                            chk("ir_instr", 32'(o_ir), 32'(e.instr));
                        end
                    end
                end
                prev_valid = (o_ir_valid === 1'b1);
                prev_ir    = o_ir;
                prev_pc    = o_ir_pc;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish by %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic r_rst;
        logic r_stall;
        logic r_load;
        apply(1'b0, 1'b0, 1'b0, 8'h00);
        repeat (3) begin
            @(negedge i_clk);
            apply(1'b0, 1'b0, 1'b0, 8'h00);
        end
        @(negedge i_clk);
        apply(1'b1, 1'b0, 1'b0, 8'h00);

        // Four-cycle stall while IR holds @5.
        wait_ir(8'h05);
        apply(1'b1, 1'b1, 1'b0, 8'h00);
        repeat (3) begin
            @(negedge i_clk);
            apply(1'b1, 1'b1, 1'b0, 8'h00);
        end
        @(negedge i_clk);
        apply(1'b1, 1'b0, 1'b0, 8'h00);

        // Branch from @10 to 8'h40.
        wait_ir(8'h0A);
        apply(1'b1, 1'b0, 1'b1, 8'h40);
        @(negedge i_clk);
        apply(1'b1, 1'b0, 1'b0, 8'h00);

        // Branch held under stall for two cycles, taken on release.
        wait_ir(8'h42);
        apply(1'b1, 1'b1, 1'b1, 8'h80);
        @(negedge i_clk);
        apply(1'b1, 1'b1, 1'b1, 8'h80);
        @(negedge i_clk);
        apply(1'b1, 1'b0, 1'b1, 8'h80);
        @(negedge i_clk);
        apply(1'b1, 1'b0, 1'b0, 8'h00);

        // Address wrap FE, FF, 00, 01.
        wait_ir(8'h83);
        apply(1'b1, 1'b0, 1'b1, 8'hFE);
        @(negedge i_clk);
        apply(1'b1, 1'b0, 1'b0, 8'h00);
        wait_ir(8'h02);

        // Fill the queue under stall, then pulse reset.
        apply(1'b1, 1'b1, 1'b0, 8'h00);
        repeat (2) begin
            @(negedge i_clk);
            apply(1'b1, 1'b1, 1'b0, 8'h00);
        end
        @(negedge i_clk);
        apply(1'b0, 1'b1, 1'b0, 8'h00);
        @(negedge i_clk);
        apply(1'b1, 1'b0, 1'b0, 8'h00);
        wait_ir(8'h03);

        repeat (600) begin
            @(negedge i_clk);
            r_rst   = ($urandom_range(63) != 0);
            r_stall = ($urandom_range(3) == 0);
            r_load  = ($urandom_range(5) == 0);
            apply(r_rst, r_stall, r_load, 8'($urandom));
        end
        repeat (8) begin
            @(negedge i_clk);
            apply(1'b1, 1'b0, 1'b0, 8'h00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
